// File: rtl/types.sv
// Shared type definitions for the router input path.
//   flit_t      : one flit as carried on the router's input port
//   arb_state_t : flit_input_arbiter FSM state, exported for debug visibility
package types;

    typedef logic [31:0] flit_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCK_NOC = 2'd1,
        ST_LOCK_CPU = 2'd2
    } arb_state_t;

endpackage

// File: rtl/flit_input_arbiter_if.sv
// Signal bundle around flit_input_arbiter.
//   noc_flit*            : link-side source (flit, valid, is_tail in; ready out of arbiter)
//   cpu_flit*            : CPU injection source (same shape as the link side)
//   transfered_flit*     : granted flit towards the router (ready comes from the router)
//   transfered_head_flit : head flit of the packet currently being forwarded
//   is_from_cpu          : granted flit originates from the CPU source
//   packet_abort         : one-cycle pulse when the watchdog drops a locked packet
//   dbg_*                : FSM state, stall counter and round-robin pointer for observation
// Handshake: a flit moves when valid and ready are both high in the same cycle; a source
// holding valid without seeing ready keeps its flit and is_tail stable until it is taken.
// Modport master is the environment side (sources + router), slave is the arbiter.
interface flit_input_arbiter_if;

    types::flit_t       noc_flit;
    logic               noc_flit_valid;
    logic               noc_flit_is_tail;
    logic               noc_flit_ready;

    types::flit_t       cpu_flit;
    logic               cpu_flit_valid;
    logic               cpu_flit_is_tail;
    logic               cpu_flit_ready;

    types::flit_t       transfered_flit;
    logic               transfered_flit_valid;
    logic               transfered_flit_ready;
    types::flit_t       transfered_head_flit;
    logic               is_from_cpu;
    logic               packet_abort;

    types::arb_state_t  dbg_state;
    logic [15:0]        dbg_stall_cnt;
    logic               dbg_prio_cpu;

    modport master (
        output noc_flit, noc_flit_valid, noc_flit_is_tail,
        input  noc_flit_ready,
        output cpu_flit, cpu_flit_valid, cpu_flit_is_tail,
        input  cpu_flit_ready,
        input  transfered_flit, transfered_flit_valid,
        output transfered_flit_ready,
        input  transfered_head_flit, is_from_cpu, packet_abort,
        input  dbg_state, dbg_stall_cnt, dbg_prio_cpu
    );

    modport slave (
        input  noc_flit, noc_flit_valid, noc_flit_is_tail,
        output noc_flit_ready,
        input  cpu_flit, cpu_flit_valid, cpu_flit_is_tail,
        output cpu_flit_ready,
        output transfered_flit, transfered_flit_valid,
        input  transfered_flit_ready,
        output transfered_head_flit, is_from_cpu, packet_abort,
        output dbg_state, dbg_stall_cnt, dbg_prio_cpu
    );

endinterface

// File: rtl/flit_input_arbiter.sv
// flit_input_arbiter
// Shares the router's single flit input between the link receiver and the local CPU.
// A grant is held from head flit to tail flit so packets never interleave; between
// packets the sources alternate round-robin. A watchdog drops a locked packet whose
// source (or the router) stalls for STALL_TIMEOUT consecutive cycles.
// Ports:
//   nocclk : clock, all state on the rising edge
//   rst    : asynchronous reset, active-high; also forces all outputs inactive while high
//   bus    : flit_input_arbiter_if.slave (both sources, router side, debug state)
module flit_input_arbiter #(
    parameter int  STALL_TIMEOUT = 16,
    localparam int CNT_W         = $clog2(STALL_TIMEOUT + 1)
) (
    input  logic                  nocclk,
    input  logic                  rst,
    flit_input_arbiter_if.slave   bus
);

    import types::*;

    arb_state_t        state_q, state_d;
    logic              prio_cpu_q, prio_cpu_d;
    flit_t             head_q, head_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    // IDLE winner latch: once a winner is shown without being taken, keep it.
    logic              hold_q, hold_d;
    logic              hold_cpu_q, hold_cpu_d;

    logic              held_live;
    logic              grant_cpu;
    logic              grant_valid;
    logic              grant_tail;
    flit_t             grant_flit;
    logic              xfer;
    logic              timeout_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prio_cpu_q  <= 1'b0;
            head_q      <= '0;
            stall_cnt_q <= '0;
            hold_q      <= 1'b0;
            hold_cpu_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_cpu_q  <= prio_cpu_d;
            head_q      <= head_d;
            stall_cnt_q <= stall_cnt_d;
            hold_q      <= hold_d;
            hold_cpu_q  <= hold_cpu_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        prio_cpu_d  = prio_cpu_q;
        head_d      = head_q;
        stall_cnt_d = stall_cnt_q;
        hold_d      = 1'b0;
        hold_cpu_d  = hold_cpu_q;

        unique case (state_q)
            ST_IDLE: begin
                stall_cnt_d = '0;
                // Remember a shown-but-not-taken winner so a late rival cannot steal it.
                hold_d      = grant_valid && !xfer;
                hold_cpu_d  = grant_cpu;
                if (xfer) begin
                    head_d = grant_flit;
                    if (grant_tail) begin
                        // Single-flit packet: hand priority to the other source.
                        prio_cpu_d = !grant_cpu;
                    end else begin
                        state_d = grant_cpu ? ST_LOCK_CPU : ST_LOCK_NOC;
                    end
                end
            end

            default: begin
                // LOCK_NOC / LOCK_CPU. Ending the packet (tail or abort) always
                // gives priority to the source that was not locked.
                if (xfer) begin
                    stall_cnt_d = '0;
                    if (grant_tail) begin
                        state_d    = ST_IDLE;
                        prio_cpu_d = (state_q == ST_LOCK_NOC);
                    end
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    stall_cnt_d = '0;
                    prio_cpu_d  = (state_q == ST_LOCK_NOC);
                end else begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant resolution and outputs (pure mux, no register stage)
    // ------------------------------------------------------------------
    always_comb begin
        // A latched winner only counts while it still presents valid; if it
        // withdrew, fall back to normal arbitration rather than deadlock.
        held_live = hold_q && (hold_cpu_q ? bus.cpu_flit_valid : bus.noc_flit_valid);

        grant_cpu = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (held_live) begin
                    grant_cpu = hold_cpu_q;
                end else if (bus.cpu_flit_valid && bus.noc_flit_valid) begin
                    grant_cpu = prio_cpu_q;
                end else begin
                    grant_cpu = bus.cpu_flit_valid;
                end
            end
            ST_LOCK_CPU: grant_cpu = 1'b1;
            default:     grant_cpu = 1'b0;
        endcase

        grant_flit  = grant_cpu ? bus.cpu_flit         : bus.noc_flit;
        grant_valid = grant_cpu ? bus.cpu_flit_valid   : bus.noc_flit_valid;
        grant_tail  = grant_cpu ? bus.cpu_flit_is_tail : bus.noc_flit_is_tail;
        xfer        = grant_valid && bus.transfered_flit_ready && !rst;

        // Counter already holds STALL_TIMEOUT-1 stalled cycles: this one is the last.
        timeout_hit = (state_q != ST_IDLE) && !xfer &&
                      (stall_cnt_q == CNT_W'(STALL_TIMEOUT - 1));

        bus.transfered_flit       = grant_flit;
        bus.transfered_flit_valid = grant_valid && !rst;
        bus.is_from_cpu           = grant_cpu && !rst;
        bus.cpu_flit_ready        = grant_cpu && bus.transfered_flit_ready && !rst;
        bus.noc_flit_ready        = !grant_cpu && bus.transfered_flit_ready && !rst;
        if (rst) begin
            bus.transfered_head_flit = '0;
        end else if (state_q == ST_IDLE) begin
            bus.transfered_head_flit = grant_flit;
        end else begin
            bus.transfered_head_flit = head_q;
        end
        bus.packet_abort          = timeout_hit && !rst;

        bus.dbg_state             = state_q;
        bus.dbg_stall_cnt         = 16'(stall_cnt_q);
        bus.dbg_prio_cpu          = prio_cpu_q;
    end

endmodule

// File: tb/tb_flit_input_arbiter.sv
// Self-checking bench for flit_input_arbiter: directed vectors, expected transfers pushed
// into a queue by the stimulus, popped and compared by an independent monitor.
module tb_flit_input_arbiter;

    import types::*;

    localparam int W = 65;   // {is_from_cpu, head flit, flit}

    logic nocclk = 1'b0;
    logic rst    = 1'b1;

    always #5 nocclk = ~nocclk;

    flit_input_arbiter_if bus ();

    flit_input_arbiter #(.STALL_TIMEOUT(16)) dut (
        .nocclk (nocclk),
        .rst    (rst),
        .bus    (bus)
    );

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // ---------------- clock/reset helpers ----------------
    task automatic next_cycle();
        @(posedge nocclk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge nocclk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic nv, input flit_t nf, input logic nt,
                         input logic cv, input flit_t cf, input logic ct,
                         input logic rdy);
        bus.noc_flit              = nf;
        bus.noc_flit_valid        = nv;
        bus.noc_flit_is_tail      = nt;
        bus.cpu_flit              = cf;
        bus.cpu_flit_valid        = cv;
        bus.cpu_flit_is_tail      = ct;
        bus.transfered_flit_ready = rdy;
    endtask

    task automatic expect_xfer(input logic from_cpu, input flit_t head, input flit_t f);
        exp_q.push_back({from_cpu, head, f});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    always @(negedge nocclk) begin
        if (!rst && bus.transfered_flit_valid && bus.transfered_flit_ready) begin
            mon_got = {bus.is_from_cpu, bus.transfered_head_flit, bus.transfered_flit};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL xfer_unexpected: got %0h expected no transfer", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got === mon_exp) n_pass++;
                else $display("FAIL xfer: got %0h expected %0h", mon_got, mon_exp);
            end
        end
    end

    // ---------------- global time limit ----------------
    initial begin
        #50000;
        $display("FAIL timeout: got simulation still running expected finish");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset with both sources valid and router ready
        rst = 1'b1;
        drive(1'b1, 32'h0000_0A00, 1'b1, 1'b1, 32'h0000_0C00, 1'b1, 1'b1);
        repeat (2) @(posedge nocclk);
        at_sample();
        check("rst_noc_ready",  64'(bus.noc_flit_ready),        64'd0);
        check("rst_cpu_ready",  64'(bus.cpu_flit_ready),        64'd0);
        check("rst_valid",      64'(bus.transfered_flit_valid), 64'd0);
        check("rst_abort",      64'(bus.packet_abort),          64'd0);
        check("rst_from_cpu",   64'(bus.is_from_cpu),           64'd0);
        check("rst_head",       64'(bus.transfered_head_flit),  64'd0);
        check("rst_state",      64'(bus.dbg_state),             64'(ST_IDLE));
        next_cycle();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        next_cycle();

        // Single-flit tie: NOC, CPU, NOC
        drive(1'b1, 32'h0000_0A01, 1'b1, 1'b1, 32'h0000_0C01, 1'b1, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A01, 32'h0000_0A01);
        at_sample();
        check("tie1_noc_ready", 64'(bus.noc_flit_ready), 64'd1);
        check("tie1_cpu_ready", 64'(bus.cpu_flit_ready), 64'd0);
        next_cycle();
        drive(1'b1, 32'h0000_0A02, 1'b1, 1'b1, 32'h0000_0C01, 1'b1, 1'b1);
        expect_xfer(1'b1, 32'h0000_0C01, 32'h0000_0C01);
        at_sample();
        check("tie2_cpu_ready", 64'(bus.cpu_flit_ready), 64'd1);
        check("tie2_noc_ready", 64'(bus.noc_flit_ready), 64'd0);
        next_cycle();
        drive(1'b1, 32'h0000_0A02, 1'b1, 1'b1, 32'h0000_0C02, 1'b1, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A02, 32'h0000_0A02);
        at_sample();
        next_cycle();

        // 3-flit CPU packet while NOC stays valid (CPU has priority now)
        drive(1'b1, 32'h0000_0A03, 1'b1, 1'b1, 32'h0000_0C10, 1'b0, 1'b1);
        expect_xfer(1'b1, 32'h0000_0C10, 32'h0000_0C10);
        at_sample();
        check("pkt1_noc_ready", 64'(bus.noc_flit_ready), 64'd0);
        next_cycle();
        drive(1'b1, 32'h0000_0A03, 1'b1, 1'b1, 32'h0000_0C11, 1'b0, 1'b1);
        expect_xfer(1'b1, 32'h0000_0C10, 32'h0000_0C11);
        at_sample();
        check("pkt2_noc_ready", 64'(bus.noc_flit_ready), 64'd0);
        check("pkt2_state",     64'(bus.dbg_state),      64'(ST_LOCK_CPU));
        next_cycle();
        drive(1'b1, 32'h0000_0A03, 1'b1, 1'b1, 32'h0000_0C12, 1'b1, 1'b1);
        expect_xfer(1'b1, 32'h0000_0C10, 32'h0000_0C12);
        at_sample();
        check("pkt3_noc_ready", 64'(bus.noc_flit_ready), 64'd0);
        next_cycle();
        // CPU still valid, but the packet just finished so NOC wins the tie
        drive(1'b1, 32'h0000_0A03, 1'b1, 1'b1, 32'h0000_0C13, 1'b1, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A03, 32'h0000_0A03);
        at_sample();
        check("post_pkt_from_cpu", 64'(bus.is_from_cpu), 64'd0);
        next_cycle();

        // Backpressure: 5 stalled cycles mid-packet, no abort
        drive(1'b1, 32'h0000_0A20, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A20, 32'h0000_0A20);
        at_sample();
        next_cycle();
        drive(1'b1, 32'h0000_0A21, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            at_sample();
            check("bp_valid", 64'(bus.transfered_flit_valid), 64'd1);
            check("bp_flit",  64'(bus.transfered_flit),       64'h0000_0A21);
            check("bp_abort", 64'(bus.packet_abort),          64'd0);
            next_cycle();
        end
        drive(1'b1, 32'h0000_0A21, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A20, 32'h0000_0A21);
        at_sample();
        check("bp_stall_cnt", 64'(bus.dbg_stall_cnt), 64'd5);
        next_cycle();
        drive(1'b1, 32'h0000_0A22, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A20, 32'h0000_0A22);
        at_sample();
        next_cycle();

        // Stall: CPU head taken, CPU goes silent for 16 cycles
        drive(1'b0, '0, 1'b0, 1'b1, 32'h0000_0C30, 1'b0, 1'b1);
        expect_xfer(1'b1, 32'h0000_0C30, 32'h0000_0C30);
        at_sample();
        next_cycle();
        drive(1'b1, 32'h0000_0A40, 1'b1, 1'b0, 32'h0000_0C31, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            at_sample();
            check("stall_abort", 64'(bus.packet_abort), (k == 16) ? 64'd1 : 64'd0);
            check("stall_noc_ready", 64'(bus.noc_flit_ready), 64'd0);
            next_cycle();
        end
        expect_xfer(1'b0, 32'h0000_0A40, 32'h0000_0A40);
        at_sample();
        check("after_abort_pulse", 64'(bus.packet_abort), 64'd0);
        check("after_abort_state", 64'(bus.dbg_state),    64'(ST_IDLE));
        next_cycle();

        // Reset in LOCK_NOC after two flits
        drive(1'b1, 32'h0000_0A50, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A50, 32'h0000_0A50);
        at_sample();
        next_cycle();
        drive(1'b1, 32'h0000_0A51, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A50, 32'h0000_0A51);
        at_sample();
        next_cycle();
        drive(1'b1, 32'h0000_0A52, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        at_sample();
        check("mid_rst_valid", 64'(bus.transfered_flit_valid), 64'd0);
        check("mid_rst_ready", 64'(bus.noc_flit_ready),        64'd0);
        check("mid_rst_state", 64'(bus.dbg_state),             64'(ST_IDLE));
        check("mid_rst_prio",  64'(bus.dbg_prio_cpu),          64'd0);
        check("mid_rst_abort", 64'(bus.packet_abort),          64'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 32'h0000_0A60, 1'b1, 1'b1, 32'h0000_0C60, 1'b1, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A60, 32'h0000_0A60);
        at_sample();
        next_cycle();

        // IDLE winner held while router not ready; late CPU must not steal it
        drive(1'b1, 32'h0000_0A70, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        at_sample();
        check("hold1_from_cpu", 64'(bus.is_from_cpu),           64'd0);
        check("hold1_valid",    64'(bus.transfered_flit_valid), 64'd1);
        next_cycle();
        drive(1'b1, 32'h0000_0A70, 1'b1, 1'b1, 32'h0000_0C70, 1'b1, 1'b0);
        at_sample();
        check("hold2_from_cpu", 64'(bus.is_from_cpu),     64'd0);
        check("hold2_flit",     64'(bus.transfered_flit), 64'h0000_0A70);
        next_cycle();
        drive(1'b1, 32'h0000_0A70, 1'b1, 1'b1, 32'h0000_0C70, 1'b1, 1'b1);
        expect_xfer(1'b0, 32'h0000_0A70, 32'h0000_0A70);
        at_sample();
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h0000_0C70, 1'b1, 1'b1);
        expect_xfer(1'b1, 32'h0000_0C70, 32'h0000_0C70);
        at_sample();
        next_cycle();

        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        repeat (3) next_cycle();

        // ---------------- final report ----------------
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
